// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between the MEM stage, the DMA/loader port and the single-port data RAM.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface data_memory_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [31:0] dma_rdata;
  logic        dma_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        oob_err;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall, dma_rdata, dma_ack,
    output mem_addr, mem_wdata, mem_we, mem_re, oob_err
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall, dma_rdata, dma_ack,
    input  mem_addr, mem_wdata, mem_we, mem_re, oob_err
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// CPU-priority arbiter for the single-port data RAM with a DMA starvation guard.
// Grants, stall, ack and RAM controls are combinational; only the FSM, counters and oob flag are registered.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   CPU_PRI   | CPU wins whenever it requests; DMA gets idle CPU cycles
//   DMA_FORCE | DMA starved too long: DMA owns the RAM for up to BURST_LEN grants
module data_memory_arbiter #(
  parameter int          MEMORY_DEPTH = 64,
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
  parameter int          MAX_WAIT     = 4,
  parameter int          BURST_LEN    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  data_memory_arbiter_if.slave  bus
);

  localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int BURST_W = $clog2(BURST_LEN + 1);

  typedef enum logic {CPU_PRI, DMA_FORCE} state_t;

  state_t               state, state_nxt;
  logic [WAIT_W-1:0]    wait_cnt, wait_nxt, wait_inc;
  logic [BURST_W-1:0]   burst_cnt, burst_nxt, burst_inc;
  logic                 oob_q;
  logic                 cpu_gnt, dma_gnt, any_gnt;
  logic                 sel_we, in_range;
  logic [31:0]          sel_addr, sel_wdata, word_idx;

  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (state == DMA_FORCE) begin
      dma_gnt = bus.dma_req;
    end else begin
      cpu_gnt = bus.cpu_req;
      dma_gnt = bus.dma_req & ~bus.cpu_req;
    end
  end

  assign any_gnt   = cpu_gnt | dma_gnt;
  assign sel_addr  = dma_gnt ? bus.dma_addr  : bus.cpu_addr;
  assign sel_wdata = dma_gnt ? bus.dma_wdata : bus.cpu_wdata;
  assign sel_we    = dma_gnt ? bus.dma_we    : bus.cpu_we;
  // Addresses below the base wrap to huge indices and fall out of range naturally.
  assign word_idx  = (sel_addr - BASE_ADDR) >> 2;
  assign in_range  = word_idx < 32'(MEMORY_DEPTH);

  assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt;
  assign bus.dma_ack   = bus.dma_req & dma_gnt;
  assign bus.mem_addr  = any_gnt ? word_idx  : 32'd0;
  assign bus.mem_wdata = any_gnt ? sel_wdata : 32'd0;
  assign bus.mem_we    = any_gnt & sel_we & in_range;
  assign bus.mem_re    = any_gnt & ~sel_we & in_range;
  assign bus.cpu_rdata = (cpu_gnt & ~bus.cpu_we & in_range) ? bus.mem_rdata : 32'd0;
  assign bus.dma_rdata = (dma_gnt & ~bus.dma_we & in_range) ? bus.mem_rdata : 32'd0;
  assign bus.oob_err   = oob_q;

  assign wait_inc  = wait_cnt + WAIT_W'(1);
  assign burst_inc = burst_cnt + BURST_W'(1);

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    burst_nxt = burst_cnt;
    case (state)
      CPU_PRI: begin
        burst_nxt = '0;
        if (bus.dma_req && cpu_gnt) begin
          if (wait_inc == WAIT_W'(MAX_WAIT)) begin
            state_nxt = DMA_FORCE;
            wait_nxt  = '0;
          end else begin
            wait_nxt = wait_inc;
          end
        end else begin
          wait_nxt = '0;
        end
      end
      DMA_FORCE: begin
        wait_nxt = '0;
        // A dropped request ends the burst early; the CPU regains priority next cycle.
        if (bus.dma_req && (burst_inc != BURST_W'(BURST_LEN))) begin
          burst_nxt = burst_inc;
        end else begin
          state_nxt = CPU_PRI;
          burst_nxt = '0;
        end
      end
      default: begin
        state_nxt = CPU_PRI;
        wait_nxt  = '0;
        burst_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= CPU_PRI;
      wait_cnt  <= '0;
      burst_cnt <= '0;
      oob_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      burst_cnt <= burst_nxt;
      if (any_gnt && !in_range) begin
        oob_q <= 1'b1;
      end
    end
  end

endmodule
